// File: rtl/vio_cmd_sink.sv
// vio port responder: parses CPU word stream into packets, buffers whole packets, delivers over valid/ready.
// Optional trailing checksum word per packet when VIO_CMD_SINK_CHECKSUM_EN is defined.
module vio_cmd_sink #(
    parameter int          DEPTH_LOG2 = 5,
    parameter logic [7:0]  VERSION    = 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vio_en,
    input  logic        vio_strobe,
    input  logic [15:0] vio_din,
    output logic [15:0] vio_dout,
    output logic [15:0] vio_cfg,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [7:0]  pkt_op,
    output logic [15:0] pkt_data,
    output logic        pkt_first,
    output logic        pkt_last
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef VIO_CMD_SINK_CHECKSUM_EN
    localparam logic [8:0] CKS_WORDS = 9'd1;
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP, S_CHECK} state_t;
`else
    localparam logic [8:0] CKS_WORDS = 9'd0;
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_t;
`endif

    state_t          r_state, w_state;
    logic [PW-1:0]   r_rd, r_wrs, r_wrc, w_rd, w_wrs, w_wrc;
    logic [7:0]      r_op, r_len, r_cnt, w_op, w_len, w_cnt;
    logic [8:0]      r_drop, w_drop;
    logic            r_ovf, r_cks_err, w_ovf, w_cks_err;
    logic [15:0]     r_dout;
    logic [25:0]     r_mem [DEPTH];
    logic            w_we, w_pop;
    logic [25:0]     w_wdata;
    logic [PW-1:0]   w_used, w_lvl;
    logic [11:0]     w_free, w_need;
    logic [8:0]      w_hdr_drop;
`ifdef VIO_CMD_SINK_CHECKSUM_EN
    logic [15:0]     r_cks, w_cks;
`endif

    assign pkt_valid = (r_rd != r_wrc);
    assign {pkt_first, pkt_last, pkt_op, pkt_data} = r_mem[r_rd[DEPTH_LOG2-1:0]];
    assign vio_cfg   = {VERSION, 3'b000, 5'(DEPTH_LOG2)};
    assign vio_dout  = r_dout;

    assign w_pop      = pkt_valid & pkt_ready;
    assign w_used     = r_wrs - r_rd;
    assign w_free     = 12'(DEPTH) - 12'(w_used);
    assign w_need     = (vio_din[7:0] == 8'd0) ? 12'd1 : {4'd0, vio_din[7:0]};
    // Words to swallow after a rejected or control header (payload plus checksum, if any).
    assign w_hdr_drop = {1'b0, vio_din[7:0]} + CKS_WORDS;

    always_comb begin
        w_state   = r_state;
        w_rd      = r_rd + {{(PW-1){1'b0}}, w_pop};
        w_wrs     = r_wrs;
        w_wrc     = r_wrc;
        w_op      = r_op;
        w_len     = r_len;
        w_cnt     = r_cnt;
        w_drop    = r_drop;
        w_ovf     = r_ovf;
        w_cks_err = r_cks_err;
        w_we      = 1'b0;
        w_wdata   = '0;
`ifdef VIO_CMD_SINK_CHECKSUM_EN
        w_cks     = r_cks;
`endif
        if (!vio_en) begin
            w_state = S_IDLE;
            w_rd    = '0;
            w_wrs   = '0;
            w_wrc   = '0;
            w_ovf   = 1'b0;
        end else if (vio_strobe) begin
            case (r_state)
                S_IDLE: begin
`ifdef VIO_CMD_SINK_CHECKSUM_EN
                    w_cks = vio_din;
`endif
                    if (vio_din[15:8] == 8'hFF) begin
                        w_ovf     = 1'b0;
                        w_cks_err = 1'b0;
                        w_drop    = w_hdr_drop;
                        w_state   = (w_hdr_drop != 9'd0) ? S_DROP : S_IDLE;
                    end else if (w_free < w_need) begin
                        w_ovf   = 1'b1;
                        w_drop  = w_hdr_drop;
                        w_state = (w_hdr_drop != 9'd0) ? S_DROP : S_IDLE;
                    end else if (vio_din[7:0] == 8'd0) begin
                        w_we    = 1'b1;
                        w_wdata = {1'b1, 1'b1, vio_din[15:8], 16'h0000};
                        w_wrs   = r_wrs + 1'b1;
`ifdef VIO_CMD_SINK_CHECKSUM_EN
                        w_state = S_CHECK;
`else
                        w_wrc   = r_wrs + 1'b1;
`endif
                    end else begin
                        w_op    = vio_din[15:8];
                        w_len   = vio_din[7:0];
                        w_cnt   = 8'd0;
                        w_state = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    w_we    = 1'b1;
                    w_wdata = {(r_cnt == 8'd0), (r_cnt == r_len - 8'd1), r_op, vio_din};
                    w_wrs   = r_wrs + 1'b1;
                    w_cnt   = r_cnt + 8'd1;
`ifdef VIO_CMD_SINK_CHECKSUM_EN
                    w_cks   = r_cks + vio_din;
                    if (r_cnt == r_len - 8'd1) w_state = S_CHECK;
`else
                    if (r_cnt == r_len - 8'd1) begin
                        w_wrc   = r_wrs + 1'b1;
                        w_state = S_IDLE;
                    end
`endif
                end
                S_DROP: begin
                    w_drop = r_drop - 9'd1;
                    if (r_drop <= 9'd1) w_state = S_IDLE;
                end
`ifdef VIO_CMD_SINK_CHECKSUM_EN
                S_CHECK: begin
                    // A bad checksum rewinds the shadow pointer so the packet never becomes visible.
                    if (vio_din == r_cks) begin
                        w_wrc = r_wrs;
                    end else begin
                        w_wrs     = r_wrc;
                        w_cks_err = 1'b1;
                    end
                    w_state = S_IDLE;
                end
`endif
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign w_lvl = w_wrc - w_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rd      <= '0;
            r_wrs     <= '0;
            r_wrc     <= '0;
            r_op      <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_drop    <= '0;
            r_ovf     <= 1'b0;
            r_cks_err <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_state   <= w_state;
            r_rd      <= w_rd;
            r_wrs     <= w_wrs;
            r_wrc     <= w_wrc;
            r_op      <= w_op;
            r_len     <= w_len;
            r_cnt     <= w_cnt;
            r_drop    <= w_drop;
            r_ovf     <= w_ovf;
            r_cks_err <= w_cks_err;
            r_dout    <= {w_ovf, (w_state != S_IDLE), vio_en, w_cks_err, 1'b0, 11'(w_lvl)};
        end
    end

`ifdef VIO_CMD_SINK_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) r_cks <= '0;
        else       r_cks <= w_cks;
    end
`endif

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wrs[DEPTH_LOG2-1:0]] <= w_wdata;
    end
endmodule
